adma_dm_axi_b_trk: RTL and testbench

AXI write-response (B channel) tracker for the DMA datamover, successor to the single-FIFO B handler. It matches each B beat to its DMA channel by BID against the per-channel AWID table, so responses may complete in any order across channels. It keeps per-channel outstanding-write counters with backpressure, per-channel sticky error status with captured response code, and unexpected-response detection. It sits between the AW issue logic (transaction push) and the channel control FSMs (done/error pulses).

---
 rtl/adma_pkg.sv | 22 ++
 rtl/adma_b_chn_ctr.sv | 75 +++++++
 rtl/adma_dm_axi_b_trk.sv | 116 +++++++++++
 tb/tb_adma_dm_axi_b_trk.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adma_pkg.sv
// Shared definitions for the DMA datamover AXI B-channel tracker:
// BRESP encodings, error classification and per-channel status record.
package adma_pkg;

    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic              sticky;
        logic [RESP_W-1:0] code;
    } chn_sts_t;

    // SLVERR and DECERR are the only failing codes; EXOKAY counts as success.
    function automatic logic is_err(input logic [RESP_W-1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/adma_b_chn_ctr.sv
// Per-channel state for the B tracker: outstanding-write counter, sticky error
// flag with first error code, and (with ADMA_B_TIMEOUT_EN) a response timeout.
module adma_b_chn_ctr
    import adma_pkg::*;
#(
    parameter int CHN_OSTD   = 4,
    parameter int OSTD_CNT_W = 3,
    parameter int TMO_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [RESP_W-1:0]     resp,
    input  logic                  err_clr,
`ifdef ADMA_B_TIMEOUT_EN
    input  logic [TMO_W-1:0]      tmo_lim,
    output logic                  tmo,
`endif
    output logic [OSTD_CNT_W-1:0] cnt,
    output logic                  sticky,
    output logic [RESP_W-1:0]     code
);

    chn_sts_t sts;
    logic     err;

    assign err    = pop && is_err(resp);
    assign sticky = sts.sticky;
    assign code   = sts.code;

    // Simultaneous push and pop cancel; both directions saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !pop && cnt < OSTD_CNT_W'(CHN_OSTD)) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !push && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A new error beats a same-cycle clear, and then takes the new code.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts <= '0;
        end else if (err) begin
            sts.sticky <= 1'b1;
            if (!sts.sticky || err_clr) sts.code <= resp;
        end else if (err_clr) begin
            sts <= '0;
        end
    end

`ifdef ADMA_B_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_lim != '0) && (tmo_cnt >= tmo_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            if (cnt == '0 || pop)            tmo_cnt <= '0;
            else if (!tmo_hit && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;

            if (err_clr)                                 tmo <= 1'b0;
            else if (cnt != '0 && !pop && tmo_hit)       tmo <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/adma_dm_axi_b_trk.sv
// AXI B-channel tracker: matches each BID to a DMA channel's AWID, keeps
// per-channel outstanding/error state. Optional timeout via ADMA_B_TIMEOUT_EN.
module adma_dm_axi_b_trk
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int MST_ID_W      = 5,
    parameter int ATX_RESP_W    = 2,
    parameter int CHN_OSTD      = 4,
    parameter int TMO_W         = 16,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
    parameter int OSTD_CNT_W    = $clog2(CHN_OSTD + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DMA_CHN_NUM_W-1:0]          atx_chn_id,
    input  logic                              atx_vld,
    output logic                              atx_rdy,
    input  logic [DMA_CHN_NUM*MST_ID_W-1:0]   atx_id,
    input  logic [MST_ID_W-1:0]               m_bid_i,
    input  logic [ATX_RESP_W-1:0]             m_bresp_i,
    input  logic                              m_bvalid_i,
    output logic                              m_bready_o,
    output logic [DMA_CHN_NUM-1:0]            atx_done,
    output logic [DMA_CHN_NUM-1:0]            atx_dst_err,
    output logic [DMA_CHN_NUM*OSTD_CNT_W-1:0] chn_ostd_cnt,
    output logic [DMA_CHN_NUM-1:0]            chn_idle,
    output logic [DMA_CHN_NUM-1:0]            chn_err_sticky,
    output logic [DMA_CHN_NUM*ATX_RESP_W-1:0] chn_err_code,
    input  logic [DMA_CHN_NUM-1:0]            err_clr,
`ifdef ADMA_B_TIMEOUT_EN
    input  logic [TMO_W-1:0]                  tmo_lim,
    output logic [DMA_CHN_NUM-1:0]            chn_tmo,
`endif
    output logic                              unexp_b
);

    logic                                     stg_vld;
    logic [MST_ID_W-1:0]                      stg_bid;
    logic [ATX_RESP_W-1:0]                    stg_resp;
    logic [DMA_CHN_NUM-1:0][OSTD_CNT_W-1:0]   cnt;
    logic [DMA_CHN_NUM-1:0]                   push;
    logic [DMA_CHN_NUM-1:0]                   pop;
    logic                                     hit;

    // BREADY comes up the cycle after reset releases and never drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_bready_o <= 1'b0;
            stg_vld    <= 1'b0;
            stg_bid    <= '0;
            stg_resp   <= '0;
        end else begin
            m_bready_o <= 1'b1;
            stg_vld    <= m_bvalid_i && m_bready_o;
            if (m_bvalid_i && m_bready_o) begin
                stg_bid  <= m_bid_i;
                stg_resp <= m_bresp_i;
            end
        end
    end

    // Lowest-index channel with a matching AWID and work outstanding wins.
    always_comb begin
        hit = 1'b0;
        pop = '0;
        for (int k = 0; k < DMA_CHN_NUM; k++) begin
            if (stg_vld && !hit && cnt[k] != '0 &&
                atx_id[k*MST_ID_W +: MST_ID_W] == stg_bid) begin
                hit    = 1'b1;
                pop[k] = 1'b1;
            end
        end
    end

    // Out-of-range channel ids match no slot, so atx_rdy stays low for them.
    always_comb begin
        atx_rdy = 1'b0;
        push    = '0;
        for (int k = 0; k < DMA_CHN_NUM; k++) begin
            if (atx_chn_id == DMA_CHN_NUM_W'(k)) atx_rdy = cnt[k] < OSTD_CNT_W'(CHN_OSTD);
        end
        for (int k = 0; k < DMA_CHN_NUM; k++) begin
            push[k] = atx_vld && atx_rdy && (atx_chn_id == DMA_CHN_NUM_W'(k));
        end
    end

    assign unexp_b      = stg_vld && !hit;
    assign atx_done     = pop;
    assign atx_dst_err  = pop & {DMA_CHN_NUM{is_err(stg_resp)}};
    assign chn_ostd_cnt = cnt;

    for (genvar k = 0; k < DMA_CHN_NUM; k++) begin : g_chn
        adma_b_chn_ctr #(
            .CHN_OSTD   (CHN_OSTD),
            .OSTD_CNT_W (OSTD_CNT_W),
            .TMO_W      (TMO_W)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .push    (push[k]),
            .pop     (pop[k]),
            .resp    (stg_resp),
            .err_clr (err_clr[k]),
`ifdef ADMA_B_TIMEOUT_EN
            .tmo_lim (tmo_lim),
            .tmo     (chn_tmo[k]),
`endif
            .cnt     (cnt[k]),
            .sticky  (chn_err_sticky[k]),
            .code    (chn_err_code[k*ATX_RESP_W +: ATX_RESP_W])
        );
        assign chn_idle[k] = (cnt[k] == '0);
    end

endmodule

// File: tb/tb_adma_dm_axi_b_trk.sv
// Randomized scoreboard bench for adma_dm_axi_b_trk (default build, timeout
// feature off). Driver updates a count/flag model; monitor checks pulses.
module tb_adma_dm_axi_b_trk;

    localparam int N    = 4;
    localparam int IDW  = 5;
    localparam int RW   = 2;
    localparam int OSTD = 4;
    localparam int CNTW = 3;
    localparam int CHW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [CHW-1:0]    atx_chn_id;
    logic              atx_vld;
    logic              atx_rdy;
    logic [N*IDW-1:0]  atx_id;
    logic [IDW-1:0]    m_bid_i;
    logic [RW-1:0]     m_bresp_i;
    logic              m_bvalid_i;
    logic              m_bready_o;
    logic [N-1:0]      atx_done;
    logic [N-1:0]      atx_dst_err;
    logic [N*CNTW-1:0] chn_ostd_cnt;
    logic [N-1:0]      chn_idle;
    logic [N-1:0]      chn_err_sticky;
    logic [N*RW-1:0]   chn_err_code;
    logic [N-1:0]      err_clr;
    logic              unexp_b;

    adma_dm_axi_b_trk dut (
        .clk(clk), .rst(rst), .atx_chn_id(atx_chn_id), .atx_vld(atx_vld),
        .atx_rdy(atx_rdy), .atx_id(atx_id), .m_bid_i(m_bid_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .atx_done(atx_done), .atx_dst_err(atx_dst_err),
        .chn_ostd_cnt(chn_ostd_cnt), .chn_idle(chn_idle),
        .chn_err_sticky(chn_err_sticky), .chn_err_code(chn_err_code),
        .err_clr(err_clr), .unexp_b(unexp_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic         unexp;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;

    // Reference state
    int           mc[N];
    bit           ms[N];
    logic [RW-1:0] mcode[N];
    bit           mbrdy;
    bit           pend;
    logic [IDW-1:0] pbid;
    logic [RW-1:0]  presp;
    logic [IDW-1:0] ids[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation whenever the DUT reports a B outcome.
    always @(negedge clk) begin
        exp_t e;
        if ((atx_done | atx_dst_err) != '0 || unexp_b) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL b_outcome: unexpected done=%b err=%b unexp=%b", atx_done, atx_dst_err, unexp_b);
            end else begin
                e = q.pop_front();
                if (atx_done !== e.done || atx_dst_err !== e.err || unexp_b !== e.unexp) begin
                    errors++;
                    $display("FAIL b_outcome: got done=%b err=%b unexp=%b expected done=%b err=%b unexp=%b",
                             atx_done, atx_dst_err, unexp_b, e.done, e.err, e.unexp);
                end
            end
        end
    end

    // One clock: check state, resolve staged beat, drive new inputs, advance model.
    task automatic cycle(input bit do_rst, input bit do_push, input int pch,
                         input bit do_b, input logic [IDW-1:0] bid,
                         input logic [RW-1:0] resp, input logic [N-1:0] clr);
        int   k;
        exp_t e;
        bit   exp_rdy;
        @(posedge clk);
        #2;
        chk("bready", m_bready_o, mbrdy);
        for (int j = 0; j < N; j++) begin
            chk($sformatf("cnt%0d", j), chn_ostd_cnt[j*CNTW +: CNTW], mc[j]);
            chk($sformatf("idle%0d", j), chn_idle[j], mc[j] == 0);
            chk($sformatf("sticky%0d", j), chn_err_sticky[j], ms[j]);
            chk($sformatf("code%0d", j), chn_err_code[j*RW +: RW], mcode[j]);
        end
        k = -1;
        if (pend) begin
            for (int j = 0; j < N; j++)
                if (k < 0 && ids[j] == pbid && mc[j] > 0) k = j;
            e.done  = '0;
            e.err   = '0;
            e.unexp = (k < 0);
            if (k >= 0) begin
                e.done[k] = 1'b1;
                e.err[k]  = presp[1];
            end
            q.push_back(e);
        end
        rst        = do_rst;
        atx_vld    = do_push;
        atx_chn_id = CHW'(pch);
        m_bvalid_i = do_b;
        m_bid_i    = bid;
        m_bresp_i  = resp;
        err_clr    = clr;
        #1;
        exp_rdy = mc[pch] < OSTD;
        chk("atx_rdy", atx_rdy, exp_rdy);
        if (do_rst) begin
            for (int j = 0; j < N; j++) begin
                mc[j] = 0; ms[j] = 0; mcode[j] = '0;
            end
            pend  = 0;
            mbrdy = 0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (j == k && presp[1]) begin
                    if (!ms[j] || clr[j]) mcode[j] = presp;
                    ms[j] = 1;
                end else if (clr[j]) begin
                    ms[j] = 0; mcode[j] = '0;
                end
            end
            if (k >= 0) mc[k]--;
            if (do_push && exp_rdy) mc[pch]++;
            pend  = do_b && mbrdy;
            pbid  = bid;
            presp = resp;
            mbrdy = 1;
        end
    endtask

    task automatic idle_cyc(input bit do_rst);
        cycle(do_rst, 0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        int ch, n;
        logic [IDW-1:0] bid;
        ids[0] = 5'd3; ids[1] = 5'd5; ids[2] = 5'd7; ids[3] = 5'd3;
        atx_id = {ids[3], ids[2], ids[1], ids[0]};
        rst = 1; atx_vld = 0; atx_chn_id = '0; m_bvalid_i = 0;
        m_bid_i = '0; m_bresp_i = '0; err_clr = '0;
        for (int j = 0; j < N; j++) begin mc[j] = 0; ms[j] = 0; mcode[j] = '0; end
        mbrdy = 0; pend = 0; pbid = '0; presp = '0;

        repeat (3) idle_cyc(1);
        idle_cyc(0);
        // push ch1 twice then two OKAY beats on id 5
        cycle(0, 1, 1, 0, '0, '0, '0);
        cycle(0, 1, 1, 0, '0, '0, '0);
        cycle(0, 0, 1, 1, 5'd5, 2'b00, '0);
        cycle(0, 0, 1, 1, 5'd5, 2'b00, '0);
        // fill ch0, probe ch2 ready, then free one slot
        repeat (4) cycle(0, 1, 0, 0, '0, '0, '0);
        cycle(0, 1, 0, 0, '0, '0, '0);
        cycle(0, 0, 2, 1, 5'd3, 2'b01, '0);
        idle_cyc(0);
        cycle(0, 0, 0, 0, '0, '0, '0);
        // out of order: ch2 (id 7) answered before ch0
        cycle(0, 1, 2, 0, '0, '0, '0);
        cycle(0, 0, 0, 1, 5'd7, 2'b00, '0);
        // errors on ch3: drain ch0 first so id 3 reaches ch3
        repeat (4) cycle(0, 0, 0, 1, 5'd3, 2'b00, '0);
        cycle(0, 1, 3, 0, '0, '0, '0);
        cycle(0, 1, 3, 0, '0, '0, '0);
        cycle(0, 0, 3, 1, 5'd3, 2'b11, '0);
        cycle(0, 0, 3, 1, 5'd3, 2'b10, '0);
        idle_cyc(0);
        cycle(0, 0, 0, 0, '0, '0, 4'b1000);
        // unexpected id
        cycle(0, 0, 0, 1, 5'd9, 2'b00, '0);
        idle_cyc(0);

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            ch  = $urandom_range(0, N - 1);
            n   = $urandom_range(0, 9);
            bid = (n < 7) ? ids[$urandom_range(0, N - 1)] : IDW'($urandom_range(0, 31));
            cycle(i == 1500, $urandom_range(0, 1), ch, $urandom_range(0, 2) != 0, bid,
                  RW'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? N'($urandom_range(1, 15)) : '0);
        end
        repeat (4) idle_cyc(0);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
